// File: rtl/regfile_np.sv
// Multi-read-port register file with same-cycle write bypass, a sequential
// bulk-clear engine and a request/ack debug read port.
module regfile_np #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  input  logic                     dbg_req,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic                     dbg_ack,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {IDLE, CLEAR} clr_state_e;
  typedef enum logic {D_IDLE, D_ACK} dbg_state_e;

  logic [DATA_W-1:0] rf_q [DEPTH];

  clr_state_e        state_q, state_d;
  logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_drop_q, wr_drop_d;
  dbg_state_e        dstate_q, dstate_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

  logic in_idle;
  logic wr_ok;

  assign in_idle = (state_q == IDLE);
  assign wr_ok   = wr_en && in_idle && !((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    wr_drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        // Writes arriving while the sequencer owns the array are lost.
        wr_drop_d = wr_en;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dstate_d   = dstate_q;
    dbg_data_d = dbg_data_q;
    case (dstate_q)
      D_IDLE: begin
        if (dbg_req) begin
          dbg_data_d = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : rf_q[dbg_addr];
          dstate_d   = D_ACK;
        end
      end
      D_ACK:   dstate_d = D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      dstate_q   <= D_IDLE;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
      dstate_q   <= dstate_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (!in_idle) begin
      rf_q[clr_ptr_q[ADDR_W-1:0]] <= '0;
    end else if (wr_ok) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if ((BYPASS != 0) && wr_en && in_idle && (wr_addr == addr)) begin
        data = wr_data;
      end else begin
        data = rf_q[addr];
      end
    end
    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

  assign wr_drop  = wr_drop_q;
  assign clr_busy = (state_q == CLEAR);
  assign clr_done = clr_done_q;
  assign dbg_ack  = (dstate_q == D_ACK);
  assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_np.sv
// Directed bench for regfile_np: default build, a no-bypass build sharing its
// inputs, and a 4-port 16x16 build without a hardwired zero register.
module tb_regfile_np;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, clr_req, dbg_req;
  logic [4:0]  wr_addr, dbg_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic        wr_drop, clr_busy, clr_done, dbg_ack;
  logic [31:0] dbg_data;
  logic        nb_wr_drop, nb_clr_busy, nb_clr_done, nb_dbg_ack;
  logic [31:0] nb_dbg_data;

  logic        w_wr_en, w_clr_req, w_dbg_req;
  logic [3:0]  w_wr_addr, w_dbg_addr;
  logic [15:0] w_wr_data, w_rd_addr;
  logic [63:0] w_rd_data;
  logic        w_wr_drop, w_clr_busy, w_clr_done, w_dbg_ack;
  logic [15:0] w_dbg_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regfile_np dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop), .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  regfile_np #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(nb_wr_drop), .rd_addr(rd_addr), .rd_data(nb_rd_data), .clr_req(clr_req),
    .clr_busy(nb_clr_busy), .clr_done(nb_clr_done), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(nb_dbg_ack), .dbg_data(nb_dbg_data)
  );

  regfile_np #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(0)) dut_w (
    .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .wr_drop(w_wr_drop), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .clr_req(w_clr_req),
    .clr_busy(w_clr_busy), .clr_done(w_clr_done), .dbg_req(w_dbg_req), .dbg_addr(w_dbg_addr),
    .dbg_ack(w_dbg_ack), .dbg_data(w_dbg_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF_FFFF;
    clr_req = 1'b1; dbg_req = 1'b1;
    step(); step();
    rst = 1'b0; wr_en = 1'b0; clr_req = 1'b0; dbg_req = 1'b0;
    rd_addr = {5'd2, 5'd1};
    #1;
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL reset_regs got %h exp 0", rd_data); else pass_cnt++;
    total_cnt++;
    if ({clr_busy, clr_done, wr_drop, dbg_ack} !== 4'b0000)
      $display("FAIL reset_ctrl got %b exp 0000", {clr_busy, clr_done, wr_drop, dbg_ack});
    else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'h0) $display("FAIL reset_dbg_data got %h exp 0", dbg_data); else pass_cnt++;
    total_cnt++; if (w_clr_busy !== 1'b0) $display("FAIL reset_w_busy got %b exp 0", w_clr_busy); else pass_cnt++;
  endtask

  task automatic test_write_read();
    write1(5'd5, 32'hDEAD_BEEF);
    rd_addr = {5'd5, 5'd5};
    #1;
    total_cnt++; if (rd_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL wr_rd_p0 got %h exp deadbeef", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (rd_data[63:32] !== 32'hDEAD_BEEF) $display("FAIL wr_rd_p1 got %h exp deadbeef", rd_data[63:32]); else pass_cnt++;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    #1;
    total_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL r0_no_bypass got %h exp 0", rd_data[31:0]); else pass_cnt++;
    step();
    wr_en = 1'b0;
    #1;
    total_cnt++; if (rd_data[63:32] !== 32'h0) $display("FAIL r0_zero got %h exp 0", rd_data[63:32]); else pass_cnt++;
  endtask

  task automatic test_bypass();
    write1(5'd7, 32'h1111_1111);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rd_addr = {5'd5, 5'd7};
    #1;
    total_cnt++; if (rd_data[31:0] !== 32'hA5A5_A5A5) $display("FAIL bypass_p0 got %h exp a5a5a5a5", rd_data[31:0]); else pass_cnt++;
    total_cnt++; if (rd_data[63:32] !== 32'hDEAD_BEEF) $display("FAIL bypass_other_port got %h exp deadbeef", rd_data[63:32]); else pass_cnt++;
    total_cnt++; if (nb_rd_data[31:0] !== 32'h1111_1111) $display("FAIL nobypass_old got %h exp 11111111", nb_rd_data[31:0]); else pass_cnt++;
    step();
    wr_en = 1'b0;
    #1;
    total_cnt++; if (nb_rd_data[31:0] !== 32'hA5A5_A5A5) $display("FAIL nobypass_after got %h exp a5a5a5a5", nb_rd_data[31:0]); else pass_cnt++;
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int done_cycles = 0;
    int done_at = 0;
    for (int i = 0; i < 32; i++) write1(5'(i), 32'(i * 3));
    rd_addr = {5'd31, 5'd0};
    #1;
    total_cnt++; if (rd_data !== {32'd93, 32'd0}) $display("FAIL fill got %h exp %h", rd_data, {32'd93, 32'd0}); else pass_cnt++;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (clr_busy) busy_cycles++;
      if (clr_done) begin
        done_cycles++;
        if (done_at == 0) done_at = c;
      end
      wr_en = (c == 15); wr_addr = 5'd9; wr_data = 32'h0000_FFFF;
      clr_req = (c == 20);
      if (c == 15) begin
        rd_addr = {5'd20, 5'd9};
        #1;
        total_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL clear_no_bypass got %h exp 0", rd_data[31:0]); else pass_cnt++;
        total_cnt++; if (rd_data[63:32] !== 32'd60) $display("FAIL clear_partial got %h exp 3c", rd_data[63:32]); else pass_cnt++;
      end
      step();
      wr_en = 1'b0; clr_req = 1'b0;
      if (c == 15) begin
        total_cnt++; if (wr_drop !== 1'b1) $display("FAIL wr_drop_set got %b exp 1", wr_drop); else pass_cnt++;
      end
      if (c == 16) begin
        total_cnt++; if (wr_drop !== 1'b0) $display("FAIL wr_drop_clr got %b exp 0", wr_drop); else pass_cnt++;
      end
    end
    total_cnt++; if (busy_cycles != 32) $display("FAIL clr_busy_len got %0d exp 32", busy_cycles); else pass_cnt++;
    total_cnt++; if (done_at != 33) $display("FAIL clr_done_cycle got %0d exp 33", done_at); else pass_cnt++;
    total_cnt++; if (done_cycles != 1) $display("FAIL clr_done_pulses got %0d exp 1", done_cycles); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      total_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL cleared_r%0d got %h exp 0", i, rd_data[31:0]); else pass_cnt++;
    end
  endtask

  task automatic test_debug();
    write1(5'd3, 32'h55);
    dbg_req = 1'b1; dbg_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
    #1;
    total_cnt++; if (dbg_ack !== 1'b0) $display("FAIL dbg_c1_ack got %b exp 0", dbg_ack); else pass_cnt++;
    step();
    wr_en = 1'b0;
    total_cnt++; if (dbg_ack !== 1'b1) $display("FAIL dbg_c2_ack got %b exp 1", dbg_ack); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'h55) $display("FAIL dbg_c2_data got %h exp 55", dbg_data); else pass_cnt++;
    step();
    total_cnt++; if (dbg_ack !== 1'b0) $display("FAIL dbg_c3_ack got %b exp 0", dbg_ack); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'h55) $display("FAIL dbg_c3_hold got %h exp 55", dbg_data); else pass_cnt++;
    step();
    total_cnt++; if (dbg_ack !== 1'b1) $display("FAIL dbg_c4_ack got %b exp 1", dbg_ack); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'h66) $display("FAIL dbg_c4_data got %h exp 66", dbg_data); else pass_cnt++;
    dbg_req = 1'b0;
    step();
    total_cnt++; if (dbg_ack !== 1'b0) $display("FAIL dbg_c5_ack got %b exp 0", dbg_ack); else pass_cnt++;
    total_cnt++; if (dbg_data !== 32'h66) $display("FAIL dbg_c5_hold got %h exp 66", dbg_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    int done_seen = 0;
    write1(5'd20, 32'h20);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; clr_req = 1'b1;
    step();
    wr_en = 1'b0; clr_req = 1'b0;
    rd_addr = {5'd20, 5'd4};
    #1;
    total_cnt++; if (clr_busy !== 1'b1) $display("FAIL wr_then_clr_busy got %b exp 1", clr_busy); else pass_cnt++;
    total_cnt++; if (rd_data[31:0] !== 32'h44) $display("FAIL wr_then_clr_data got %h exp 44", rd_data[31:0]); else pass_cnt++;
    for (int c = 1; c < 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total_cnt++; if (clr_busy !== 1'b0) $display("FAIL rst_abort_busy got %b exp 0", clr_busy); else pass_cnt++;
    total_cnt++; if (rd_data !== 64'h0) $display("FAIL rst_abort_regs got %h exp 0", rd_data); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      if (clr_done) done_seen++;
      step();
    end
    total_cnt++; if (done_seen != 0) $display("FAIL rst_abort_done got %0d exp 0", done_seen); else pass_cnt++;
  endtask

  task automatic test_wide();
    int busy_cycles = 0;
    int done_at = 0;
    w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 16'hBEEF;
    step();
    w_wr_en = 1'b0; w_rd_addr = 16'h0000;
    #1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (w_rd_data[k*16 +: 16] !== 16'hBEEF) $display("FAIL wide_p%0d got %h exp beef", k, w_rd_data[k*16 +: 16]);
      else pass_cnt++;
    end
    w_clr_req = 1'b1;
    step();
    w_clr_req = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (w_clr_busy) busy_cycles++;
      if (w_clr_done && done_at == 0) done_at = c;
      step();
    end
    total_cnt++; if (busy_cycles != 16) $display("FAIL wide_busy_len got %0d exp 16", busy_cycles); else pass_cnt++;
    total_cnt++; if (done_at != 17) $display("FAIL wide_done_cycle got %0d exp 17", done_at); else pass_cnt++;
    total_cnt++; if (w_rd_data[15:0] !== 16'h0) $display("FAIL wide_cleared got %h exp 0", w_rd_data[15:0]); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    clr_req = 1'b0; dbg_req = 1'b0; dbg_addr = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;
    w_clr_req = 1'b0; w_dbg_req = 1'b0; w_dbg_addr = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_debug();
    test_reset_mid_clear();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
